// File: rtl/div_iter_if.sv
// ============================================================================
//  Module      : div_iter_if
//  Description : Request/result bundle for the iterative divider. The flush
//                line exists only when DIV_FLUSH_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sign;
    logic [WIDTH-1:0] iDividend;
    logic [WIDTH-1:0] iDivisor;
`ifdef DIV_FLUSH_EN
    logic             flush;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] oQ;
    logic [WIDTH-1:0] oR;
    logic             oDivZero;

    modport master (
`ifdef DIV_FLUSH_EN
        output flush,
`endif
        output start, sign, iDividend, iDivisor,
        input  busy, done, oQ, oR, oDivZero
    );

    modport slave (
`ifdef DIV_FLUSH_EN
        input  flush,
`endif
        input  start, sign, iDividend, iDivisor,
        output busy, done, oQ, oR, oDivZero
    );
endinterface

`default_nettype wire

// File: rtl/div_iter.sv
// ============================================================================
//  Module      : div_iter
//  Description : Multi-cycle restoring divider, signed/unsigned, WIDTH+1
//                cycle latency. Optional cancel input under DIV_FLUSH_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_iter #(
    parameter int WIDTH = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    div_iter_if.slave   bus
);
    localparam int         c_CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;

    logic [1:0]       r_state;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_dvd;
    logic             r_negq;
    logic             r_negr;
    logic             r_dz;
    logic [WIDTH-1:0] r_oq;
    logic [WIDTH-1:0] r_or;
    logic             r_odz;
    logic             r_done;

    logic             w_flush;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

`ifdef DIV_FLUSH_EN
    assign w_flush = bus.flush;
`else
    assign w_flush = 1'b0;
`endif

    // Negating the most-negative value wraps to itself, which is still the
    // correct unsigned magnitude 2^(WIDTH-1).
    assign w_a_neg = bus.sign & bus.iDividend[WIDTH-1];
    assign w_b_neg = bus.sign & bus.iDivisor[WIDTH-1];
    assign w_a_mag = w_a_neg ? -bus.iDividend : bus.iDividend;
    assign w_b_mag = w_b_neg ? -bus.iDivisor  : bus.iDivisor;

    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_div};
    assign w_ge    = ~w_diff[WIDTH];

    assign w_q_fix = r_dz ? {WIDTH{1'b1}} : (r_negq ? -r_quo : r_quo);
    assign w_r_fix = r_dz ? r_dvd         : (r_negr ? -r_rem : r_rem);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_dvd   <= '0;
            r_negq  <= 1'b0;
            r_negr  <= 1'b0;
            r_dz    <= 1'b0;
            r_oq    <= '0;
            r_or    <= '0;
            r_odz   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.start && !w_flush) begin
                        r_state <= c_RUN;
                        r_cnt   <= c_CW'(WIDTH - 1);
                        r_quo   <= w_a_mag;
                        r_rem   <= '0;
                        r_div   <= w_b_mag;
                        r_dvd   <= bus.iDividend;
                        r_negq  <= w_a_neg ^ w_b_neg;
                        r_negr  <= w_a_neg;
                        r_dz    <= (bus.iDivisor == '0);
                    end
                end
                c_RUN: begin
                    if (w_flush) begin
                        r_state <= c_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], w_ge};
                        if (r_cnt == '0) begin
                            r_state <= c_FIX;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                c_FIX: begin
                    r_state <= c_IDLE;
                    if (!w_flush) begin
                        r_oq   <= w_q_fix;
                        r_or   <= w_r_fix;
                        r_odz  <= r_dz;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = (r_state != c_IDLE);
    assign bus.done     = r_done;
    assign bus.oQ       = r_oq;
    assign bus.oR       = r_or;
    assign bus.oDivZero = r_odz;

endmodule

`default_nettype wire

// File: tb/tb_div_iter.sv
// ============================================================================
//  Module      : tb_div_iter
//  Description : Self-checking bench for div_iter against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_iter;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    div_iter_if #(.WIDTH(W)) bus ();

    div_iter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {divzero, quotient, remainder}
    function automatic logic [2*W:0] ref_div(input logic s, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (b == '0) return {1'b1, {W{1'b1}}, a};
        if (s) begin
            if (a == {1'b1, {(W-1){1'b0}}} && b == {W{1'b1}}) begin
                q = a;
                r = '0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {1'b0, q, r};
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start     = 1'b1;
        bus.sign      = s;
        bus.iDividend = a;
        bus.iDivisor  = b;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.sign      = 1'($urandom);
        bus.iDividend = $urandom;
        bus.iDivisor  = $urandom;
    endtask

    task automatic wait_check(input string tag, input logic s, input logic [W-1:0] a,
                              input logic [W-1:0] b, input bit mid_start);
        int          cyc   = 0;
        int          nbusy = 0;
        logic [2*W:0] e;
        while (!bus.done && cyc < 60) begin
            if (bus.busy) nbusy++;
            if (mid_start && cyc == 10) begin
                bus.start     = 1'b1;
                bus.sign      = 1'b1;
                bus.iDividend = 32'd9;
                bus.iDivisor  = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        e = ref_div(s, a, b);
        chk({tag, ".done"},  64'(bus.done), 64'd1);
        chk({tag, ".lat"},   64'(cyc),      64'(W + 1));
        chk({tag, ".nbusy"}, 64'(nbusy),    64'(W + 1));
        chk({tag, ".busy0"}, 64'(bus.busy), 64'd0);
        chk({tag, ".q"},     64'(bus.oQ),   64'(e[2*W-1:W]));
        chk({tag, ".r"},     64'(bus.oR),   64'(e[W-1:0]));
        chk({tag, ".dz"},    64'(bus.oDivZero), 64'(e[2*W]));
    endtask

    task automatic op(input string tag, input logic s, input logic [W-1:0] a,
                      input logic [W-1:0] b);
        @(negedge clk);
        launch(s, a, b);
        wait_check(tag, s, a, b, 1'b0);
        @(negedge clk);
        chk({tag, ".pulse1"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int          seen;
        logic        s;
        logic [W-1:0] a;
        logic [W-1:0] b;

        bus.start     = 1'b0;
        bus.sign      = 1'b0;
        bus.iDividend = '0;
        bus.iDivisor  = '0;
`ifdef DIV_FLUSH_EN
        bus.flush     = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst.busy", 64'(bus.busy), 64'd0);
        chk("rst.done", 64'(bus.done), 64'd0);
        chk("rst.q",    64'(bus.oQ),   64'd0);
        chk("rst.r",    64'(bus.oR),   64'd0);
        chk("rst.dz",   64'(bus.oDivZero), 64'd0);
        rst = 1'b0;

        op("u100_7",  1'b0, 32'd100, 32'd7);
        op("s-7_2",   1'b1, 32'hFFFFFFF9, 32'd2);
        op("u-7_2",   1'b0, 32'hFFFFFFF9, 32'd2);
        op("u5_0",    1'b0, 32'd5, 32'd0);
        op("s5_0",    1'b1, 32'hFFFFFFFB, 32'd0);
        op("sovf",    1'b1, 32'h80000000, 32'hFFFFFFFF);

        // Mid-run start is ignored, then a back-to-back start on the done cycle
        @(negedge clk);
        launch(1'b0, 32'd100, 32'd7);
        wait_check("ign", 1'b0, 32'd100, 32'd7, 1'b1);
        launch(1'b0, 32'd9, 32'd3);
        wait_check("b2b", 1'b0, 32'd9, 32'd3, 1'b0);

        // Reset during RUN
        @(negedge clk);
        launch(1'b0, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rrun.busy", 64'(bus.busy), 64'd0);
        chk("rrun.done", 64'(bus.done), 64'd0);
        chk("rrun.q",    64'(bus.oQ),   64'd0);
        chk("rrun.r",    64'(bus.oR),   64'd0);
        chk("rrun.dz",   64'(bus.oDivZero), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        chk("rrun.nodone", 64'(seen), 64'd0);

`ifdef DIV_FLUSH_EN
        op("f9_3", 1'b0, 32'd9, 32'd3);
        @(negedge clk);
        launch(1'b0, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("fl.busy", 64'(bus.busy), 64'd0);
        chk("fl.q",    64'(bus.oQ),   64'd3);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        chk("fl.nodone", 64'(seen), 64'd0);
        bus.flush = 1'b1;
        bus.start = 1'b1;
        bus.iDividend = 32'd50;
        bus.iDivisor  = 32'd5;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        chk("flst.busy", 64'(bus.busy), 64'd0);
        chk("flst.q",    64'(bus.oQ),   64'd3);
`endif

        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom);
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
            case ($urandom_range(0, 4))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFFFFFF;
                3:       b = 32'($urandom) >> $urandom_range(0, 31);
                default: b = 32'($urandom);
            endcase
            op($sformatf("rnd%0d", i), s, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

`default_nettype wire
